// File: rtl/spi_burst_ctrl.sv
// Burst feeder for the 16-bit SPI master: a TX FIFO drained one word per inicio, and an RX FIFO of returned words.
// Define SPI_CTRL_TIMEOUT_EN to abort a burst when the master never returns rx_dv within TIMEOUT_CYCLES.
module spi_burst_ctrl #(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [15:0]                i_wr_data,
  output logic                       o_tx_full,
  output logic [$clog2(DEPTH):0]     o_tx_count,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err_timeout,
  input  logic                       i_rd_en,
  output logic [15:0]                o_rd_data,
  output logic                       o_rx_empty,
  output logic                       o_rx_ovf,
  output logic                       o_spi_inicio,
  output logic [15:0]                o_spi_tx_word,
  input  logic                       i_spi_rx_dv,
  input  logic [15:0]                i_spi_rx_word
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP, S_DONE} state_t;

  state_t          r_state;
  logic            r_inicio;
  logic            r_done;
  logic            r_rx_ovf;
  logic [15:0]     r_spi_tx_word;
  logic [GW-1:0]   r_gap_cnt;

  logic [15:0]     r_tx_mem [DEPTH];
  logic [AW-1:0]   r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]   r_tx_count;
  logic [15:0]     r_rx_mem [DEPTH];
  logic [AW-1:0]   r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]   r_rx_count;

  logic w_tx_full, w_tx_push, w_tx_pop, w_tx_flush;
  logic w_rx_full, w_rx_empty, w_rx_req, w_rx_push, w_rx_pop, w_rx_drop;

  assign w_tx_full  = (r_tx_count == CW'(DEPTH));
  assign w_tx_push  = i_wr_en & ~w_tx_full;
  assign w_tx_pop   = (r_state == S_LOAD) & (r_tx_count != '0);

  assign w_rx_full  = (r_rx_count == CW'(DEPTH));
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_req   = (r_state == S_WAIT) & i_spi_rx_dv;
  assign w_rx_pop   = i_rd_en & ~w_rx_empty;
  // A full RX FIFO still accepts a word when a read frees a slot in the same cycle.
  assign w_rx_push  = w_rx_req & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = w_rx_req & w_rx_full & ~w_rx_pop;

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_to_cnt;
  logic          r_err_timeout;
  assign w_tx_flush    = (r_state == S_WAIT) & ~i_spi_rx_dv & (r_to_cnt == '0);
  assign o_err_timeout = r_err_timeout;
`else
  assign w_tx_flush    = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_flush) begin
        // A word written in the flush cycle survives as the only entry.
        r_tx_rptr  <= r_tx_wptr;
        r_tx_count <= w_tx_push ? CW'(1) : '0;
      end else begin
        if (w_tx_pop) r_tx_rptr <= r_tx_rptr + 1'b1;
        case ({w_tx_push, w_tx_pop})
          2'b10:   r_tx_count <= r_tx_count + 1'b1;
          2'b01:   r_tx_count <= r_tx_count - 1'b1;
          default: r_tx_count <= r_tx_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_spi_rx_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_inicio      <= 1'b0;
      r_done        <= 1'b0;
      r_rx_ovf      <= 1'b0;
      r_spi_tx_word <= '0;
      r_gap_cnt     <= '0;
`ifdef SPI_CTRL_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_inicio <= 1'b0;
      r_done   <= 1'b0;
      if (w_rx_drop) r_rx_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (r_tx_count != '0) begin
              r_state  <= S_LOAD;
              r_rx_ovf <= 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
              r_err_timeout <= 1'b0;
`endif
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_spi_tx_word <= r_tx_mem[r_tx_rptr];
          r_inicio      <= 1'b1;
          r_state       <= S_WAIT;
`ifdef SPI_CTRL_TIMEOUT_EN
          r_to_cnt      <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (i_spi_rx_dv) begin
            if (r_tx_count != '0) begin
              if (GAP_CYCLES > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= GAP_LOAD;
              end else begin
                r_state <= S_LOAD;
              end
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
`ifdef SPI_CTRL_TIMEOUT_EN
          else if (r_to_cnt == '0) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_DONE;
            r_done        <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (r_gap_cnt == '0) r_state <= S_LOAD;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_full     = w_tx_full;
  assign o_tx_count    = r_tx_count;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_rd_data     = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rptr];
  assign o_rx_empty    = w_rx_empty;
  assign o_rx_ovf      = r_rx_ovf;
  assign o_spi_inicio  = r_inicio;
  assign o_spi_tx_word = r_spi_tx_word;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: queue-based reference model, echoing master model (returns ~word), random bursts.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  localparam int TO    = 50;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic        i_rd_en = 1'b0;
  logic        i_spi_rx_dv;
  logic [15:0] i_spi_rx_word;
  logic        o_tx_full, o_busy, o_done, o_err_timeout, o_rx_empty, o_rx_ovf, o_spi_inicio;
  logic [4:0]  o_tx_count;
  logic [15:0] o_rd_data, o_spi_tx_word;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_tx_full(o_tx_full), .o_tx_count(o_tx_count), .i_start(i_start), .o_busy(o_busy),
    .o_done(o_done), .o_err_timeout(o_err_timeout), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_rx_empty(o_rx_empty), .o_rx_ovf(o_rx_ovf), .o_spi_inicio(o_spi_inicio),
    .o_spi_tx_word(o_spi_tx_word), .i_spi_rx_dv(i_spi_rx_dv), .i_spi_rx_word(i_spi_rx_word)
  );

  int n_total = 0, n_bad = 0;
  logic [15:0] tx_q[$], rx_q[$], pend_q[$];
  bit exp_ovf = 0, have_dv = 0, silent = 0;
  int n_inicio = 0, n_done = 0, cyc = 0, last_dv = 0, fixed_lat = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observer: model pops on inicio, RX model pushes on rx_dv, gap is measured dv->inicio.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (!i_rst) begin
      if (o_spi_inicio) begin
        logic [31:0] e;
        n_inicio++;
        e = (tx_q.size() > 0) ? {16'h0, tx_q.pop_front()} : 32'hBAD0_0000;
        check_eq("tx_word", {16'h0, o_spi_tx_word}, e);
        pend_q.push_back(~e[15:0]);
        if (have_dv) check_eq("gap", cyc - last_dv, GAP + 1);
        have_dv = 0;
      end
      if (i_spi_rx_dv) begin
        logic [15:0] r;
        r = (pend_q.size() > 0) ? pend_q.pop_front() : 16'hDEAD;
        if (rx_q.size() < DEPTH) rx_q.push_back(r);
        else exp_ovf = 1;
        have_dv = 1;
        last_dv = cyc;
      end
      if (o_done) begin
        n_done++;
        have_dv = 0;
      end
    end
  end

  // Master model: answers each inicio with ~word after a latency.
  initial begin
    logic [15:0] w;
    int lat;
    i_spi_rx_dv = 1'b0;
    i_spi_rx_word = '0;
    forever begin
      @(negedge clk);
      if (o_spi_inicio && !silent) begin
        w = o_spi_tx_word;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 25));
        repeat (lat) @(negedge clk);
        i_spi_rx_dv = 1'b1;
        i_spi_rx_word = ~w;
        @(negedge clk);
        i_spi_rx_dv = 1'b0;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    i_wr_en = 1'b1;
    i_wr_data = w;
    if (tx_q.size() < DEPTH) tx_q.push_back(w);
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 32'(n_done > d0), 1);
  endtask

  task automatic read_rx(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] e;
      e = (rx_q.size() > 0) ? {16'h0, rx_q.pop_front()} : 32'hBAD0_0000;
      check_eq("rd_data", {16'h0, o_rd_data}, e);
      i_rd_en = 1'b1;
      @(negedge clk);
      i_rd_en = 1'b0;
    end
  endtask

  initial begin
    int i0, d0, n;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_rx_empty", o_rx_empty, 1);
    check_eq("rst_tx_count", o_tx_count, 0);
    check_eq("rst_inicio", o_spi_inicio, 0);
    check_eq("rst_rd_data", o_rd_data, 0);
    check_eq("rst_ovf", o_rx_ovf, 0);
    check_eq("rst_err", o_err_timeout, 0);

    // Two-word burst, fixed latency 20
    fixed_lat = 20;
    push(16'hA5C3);
    push(16'h0F0F);
    i0 = n_inicio; d0 = n_done;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("inicio_lat1", o_spi_inicio, 0);
    @(negedge clk);
    check_eq("inicio_lat2", o_spi_inicio, 1);
    wait_done(200);
    check_eq("t2_inicio_cnt", n_inicio - i0, 2);
    @(negedge clk);
    check_eq("t2_done_cnt", n_done - d0, 1);
    check_eq("t2_busy", o_busy, 0);
    check_eq("t2_rd0", o_rd_data, 16'h5A3C);
    check_eq("t2_rd1_queue_head", rx_q.size(), 2);
    read_rx(1);
    check_eq("t2_rd1", o_rd_data, 16'hF0F0);
    read_rx(1);
    check_eq("t2_empty", o_rx_empty, 1);
    fixed_lat = 0;

    // TX full: 17th word dropped
    for (int i = 0; i < 17; i++) begin
      push(16'($urandom));
      if (i == 15) check_eq("t3_full", o_tx_full, 1);
    end
    check_eq("t3_count", o_tx_count, 16);
    i0 = n_inicio;
    start_pulse();
    wait_done(2000);
    check_eq("t3_inicio_cnt", n_inicio - i0, 16);
    @(negedge clk);
    read_rx(16);
    check_eq("t3_empty", o_rx_empty, 1);

    // RX overflow: 17 words with no reads, 17th pushed mid-burst
    for (int i = 0; i < 16; i++) push(16'($urandom));
    i0 = n_inicio;
    start_pulse();
    n = 0;
    while (n_inicio == i0 && n < 50) begin @(negedge clk); n++; end
    push(16'($urandom));
    wait_done(3000);
    @(negedge clk);
    check_eq("t4_inicio_cnt", n_inicio - i0, 17);
    check_eq("t4_ovf", o_rx_ovf, 32'(exp_ovf));
    check_eq("t4_ovf_set", 32'(exp_ovf), 1);
    read_rx(16);
    check_eq("t4_empty", o_rx_empty, 1);
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    check_eq("t4_rd_empty_still", o_rx_empty, 1);
    check_eq("t4_rd_empty_data", o_rd_data, 0);
    exp_ovf = 0;

    // Start with empty TX, then start while busy
    i0 = n_inicio;
    start_pulse();
    check_eq("t5_done_now", o_done, 1);
    @(negedge clk);
    check_eq("t5_done_gone", o_done, 0);
    check_eq("t5_idle", o_busy, 0);
    check_eq("t5_no_inicio", n_inicio - i0, 0);
    push(16'h1234);
    push(16'hBEEF);
    d0 = n_done;
    start_pulse();
    repeat (4) @(negedge clk);
    check_eq("t5_busy", o_busy, 1);
    check_eq("t5_ovf_cleared", o_rx_ovf, 0);
    start_pulse();
    wait_done(500);
    repeat (10) @(negedge clk);
    check_eq("t5_inicio_cnt", n_inicio - i0, 2);
    check_eq("t5_done_cnt", n_done - d0, 1);
    read_rx(2);

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) push(16'($urandom));
      i0 = n_inicio;
      start_pulse();
      wait_done(2000);
      @(negedge clk);
      check_eq("rnd_inicio_cnt", n_inicio - i0, n);
      check_eq("rnd_tx_count", o_tx_count, 0);
      read_rx(n);
      check_eq("rnd_empty", o_rx_empty, 1);
    end

    // Silent master
    silent = 1;
    push(16'h0001); push(16'h0002); push(16'h0003);
    d0 = n_done;
    start_pulse();
`ifdef SPI_CTRL_TIMEOUT_EN
    wait_done(200);
    check_eq("t6_err", o_err_timeout, 1);
    check_eq("t6_tx_flushed", o_tx_count, 0);
    tx_q.delete();
    pend_q.delete();
    @(negedge clk);
    check_eq("t6_idle", o_busy, 0);
    push(16'h0004); push(16'h0005);
    start_pulse();
    repeat (10) @(negedge clk);
`else
    repeat (300) @(negedge clk);
    check_eq("t6_busy_forever", o_busy, 1);
    check_eq("t6_no_done", n_done - d0, 0);
    check_eq("t6_err_tied", o_err_timeout, 0);
`endif
    check_eq("t6_pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_busy", o_busy, 0);
    check_eq("t6_rst_tx", o_tx_count, 0);
    check_eq("t6_rst_rx_empty", o_rx_empty, 1);
    check_eq("t6_rst_inicio", o_spi_inicio, 0);
    check_eq("t6_rst_err", o_err_timeout, 0);
    i_rst = 1'b0;
    tx_q.delete(); rx_q.delete(); pend_q.delete();
    have_dv = 0; exp_ovf = 0; silent = 0;
    @(negedge clk);

    // Clean burst after reset
    push(16'hC0DE);
    i0 = n_inicio;
    start_pulse();
    wait_done(200);
    @(negedge clk);
    check_eq("post_rst_inicio", n_inicio - i0, 1);
    read_rx(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end
endmodule
